// File: rtl/mem_responder_pkg.sv
// Shared constants and address decode for the memory responder and its controller.
package mem_responder_pkg;

  // Tag in addr[17:16] that selects the memory-mapped I/O window.
  localparam logic [1:0]  IO_SPACE     = 2'b11;
  localparam logic [31:0] IO_DATA_ADDR = 32'h0003_0000;
  localparam logic [31:0] IO_HALT_ADDR = 32'h0003_0004;

  // Target of one bus cycle.
  typedef enum logic [1:0] {
    SEL_RAM     = 2'd0,
    SEL_IO_DATA = 2'd1,
    SEL_IO_HALT = 2'd2,
    SEL_IO_NONE = 2'd3
  } sel_e;

  // Classify a byte address. Any address outside the I/O window is RAM;
  // unmapped I/O addresses read as zero and ignore writes.
  function automatic sel_e decode_addr(input logic [31:0] addr);
    sel_e sel;
    if (addr[17:16] != IO_SPACE) sel = SEL_RAM;
    else if (addr == IO_DATA_ADDR) sel = SEL_IO_DATA;
    else if (addr == IO_HALT_ADDR) sel = SEL_IO_HALT;
    else sel = SEL_IO_NONE;
    return sel;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Byte-wide memory bus between the memory controller (master) and the responder (slave).
interface mem_responder_if;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        io_buffer_full;

  modport master (
    output mem_a, mem_wr, mem_wdata,
    input  mem_rdata, io_buffer_full
  );

  modport slave (
    input  mem_a, mem_wr, mem_wdata,
    output mem_rdata, io_buffer_full
  );
endinterface

// File: rtl/mem_responder_io_tx_fifo.sv
// TX byte FIFO feeding the UART; reports occupancy, a registered near-full flag
// and a sticky overflow flag for bytes dropped while full.
module io_tx_fifo #(
  parameter int TX_DEPTH    = 16,
  parameter int FULL_MARGIN = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [7:0]                  din,
  input  logic                        pop,
  output logic [7:0]                  dout,
  output logic [$clog2(TX_DEPTH):0]   count,
  output logic                        near_full,
  output logic                        overflow
);
  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    slots [TX_DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] next_count;
  logic          full;
  logic          accept;

  // A push at full is still accepted when a pop frees the head slot in the same cycle.
  always_comb begin
    full       = (count == CW'(TX_DEPTH));
    accept     = push && (!full || pop);
    next_count = count + CW'(accept) - CW'(pop);
  end

  // Storage is not reset; only pointers and count define which slots are live.
  always_ff @(posedge clk) begin
    if (accept) slots[wptr] <= din;
  end

  // Pointer, occupancy and flag update; near_full looks at post-update occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      near_full <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (accept) wptr <= wptr + PW'(1);
      if (pop)    rptr <= rptr + PW'(1);
      count     <= next_count;
      near_full <= (next_count >= CW'(TX_DEPTH - FULL_MARGIN));
      if (push && !accept) overflow <= 1'b1;
    end
  end

  assign dout = slots[rptr];

endmodule

// File: rtl/mem_responder.sv
// Memory-bus responder: main RAM with one-cycle registered reads plus the
// I/O window (TX FIFO toward the UART, RX byte pass-through, halt pulse).
//
// Handshakes: tx_valid/tx_ready and rx_valid/rx_ready transfer one byte on a
// rising edge where both are high; valid never waits for ready, and data is
// stable while valid is high and ready is low.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int    ADDR_WID    = 17,
  parameter string INIT_FILE   = "",
  parameter int    TX_DEPTH    = 16,
  parameter int    FULL_MARGIN = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_responder_if.slave        bus,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  halt,
  output logic                  tx_overflow
);
  logic [7:0]              ram [0:(1 << ADDR_WID) - 1];
  logic [ADDR_WID-1:0]     ram_idx;
  sel_e                    sel;
  logic [7:0]              rdata_q;
  logic                    halt_q;
  logic                    tx_push;
  logic                    tx_pop;
  logic [$clog2(TX_DEPTH):0] tx_count;
  logic                    near_full;

  assign sel     = decode_addr(bus.mem_a);
  assign ram_idx = bus.mem_a[ADDR_WID-1:0];

  // RAM write takes effect at the edge, so a read on the next cycle sees it.
  always_ff @(posedge clk) begin
    if (bus.mem_wr && sel == SEL_RAM) ram[ram_idx] <= bus.mem_wdata;
  end

  // Read data register: updated on read cycles only, held across writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 8'h00;
    end else if (!bus.mem_wr) begin
      case (sel)
        SEL_RAM:     rdata_q <= ram[ram_idx];
        SEL_IO_DATA: rdata_q <= rx_valid ? rx_data : 8'h00;
        default:     rdata_q <= 8'h00;
      endcase
    end
  end

  // Halt is a single-cycle pulse following a write to the halt register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halt_q <= 1'b0;
    else        halt_q <= bus.mem_wr && (sel == SEL_IO_HALT);
  end

  // An IO_DATA read consumes the pending RX byte in the same cycle.
  always_comb begin
    rx_ready = rst_n && !bus.mem_wr && (sel == SEL_IO_DATA) && rx_valid;
  end

  assign tx_push  = bus.mem_wr && (sel == SEL_IO_DATA);
  assign tx_valid = (tx_count != '0);
  assign tx_pop   = tx_valid && tx_ready;

  io_tx_fifo #(
    .TX_DEPTH    (TX_DEPTH),
    .FULL_MARGIN (FULL_MARGIN)
  ) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tx_push),
    .din       (bus.mem_wdata),
    .pop       (tx_pop),
    .dout      (tx_data),
    .count     (tx_count),
    .near_full (near_full),
    .overflow  (tx_overflow)
  );

  assign bus.mem_rdata      = rdata_q;
  assign bus.io_buffer_full = near_full;
  assign halt               = halt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder: RAM access, TX FIFO throttling and
// overflow, RX reads, halt pulse and asynchronous reset.
module tb_mem_responder;
  import mem_responder_pkg::*;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if bus ();

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       halt;
  logic       tx_overflow;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  mem_responder #(
    .ADDR_WID    (17),
    .INIT_FILE   (""),
    .TX_DEPTH    (16),
    .FULL_MARGIN (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .halt        (halt),
    .tx_overflow (tx_overflow)
  );

  // Scoreboard comparison
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after a rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.mem_a     = 32'h0000_0010;
    bus.mem_wr    = 1'b0;
    bus.mem_wdata = 8'h00;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [7:0] data);
    bus.mem_a     = addr;
    bus.mem_wr    = 1'b1;
    bus.mem_wdata = data;
    tick();
  endtask

  task automatic rd(input logic [31:0] addr);
    bus.mem_a  = addr;
    bus.mem_wr = 1'b0;
    tick();
  endtask

  // Pops everything in exp_q and compares against tx_data in order.
  task automatic drain(input string tag);
    idle();
    tx_ready = 1'b1;
    while (exp_q.size() > 0) begin
      check({tag, "_valid"}, {31'd0, tx_valid}, 32'd1);
      check({tag, "_data"}, {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      tick();
    end
    tx_ready = 1'b0;
    check({tag, "_empty"}, {31'd0, tx_valid}, 32'd0);
  endtask

  initial begin
    bus.mem_a     = IO_DATA_ADDR;
    bus.mem_wr    = 1'b0;
    bus.mem_wdata = 8'h00;
    tx_ready      = 1'b0;
    rx_valid      = 1'b1;
    rx_data       = 8'h66;

    // Reset values (rx_ready must stay low even with an IO_DATA read pending)
    #2;
    check("rst_rdata", {24'd0, bus.mem_rdata}, 32'h00);
    check("rst_full", {31'd0, bus.io_buffer_full}, 32'd0);
    check("rst_halt", {31'd0, halt}, 32'd0);
    check("rst_ovf", {31'd0, tx_overflow}, 32'd0);
    check("rst_txv", {31'd0, tx_valid}, 32'd0);
    check("rst_rxr", {31'd0, rx_ready}, 32'd0);
    tick();
    tick();
    rx_valid = 1'b0;
    idle();
    rst_n = 1'b1;

    // RAM write then read on the next cycle; write cycle holds rdata
    wr(32'h0000_0010, 8'hA5);
    rd(32'h0000_0010);
    check("ram_raw", {24'd0, bus.mem_rdata}, 32'hA5);
    wr(32'h0000_0020, 8'h77);
    check("ram_wr_hold", {24'd0, bus.mem_rdata}, 32'hA5);
    rd(32'h0000_0020);
    check("ram_rd2", {24'd0, bus.mem_rdata}, 32'h77);

    // Burst read, one byte per cycle
    wr(32'h0000_0100, 8'h13);
    wr(32'h0000_0101, 8'h00);
    wr(32'h0000_0102, 8'h00);
    wr(32'h0000_0103, 8'h00);
    wr(32'h0000_0200, 8'h11);
    wr(32'h0000_0201, 8'h22);
    wr(32'h0000_0202, 8'h33);
    wr(32'h0000_0203, 8'h44);
    rd(32'h0000_0100); check("burst0", {24'd0, bus.mem_rdata}, 32'h13);
    rd(32'h0000_0101); check("burst1", {24'd0, bus.mem_rdata}, 32'h00);
    rd(32'h0000_0102); check("burst2", {24'd0, bus.mem_rdata}, 32'h00);
    rd(32'h0000_0103); check("burst3", {24'd0, bus.mem_rdata}, 32'h00);
    rd(32'h0000_0200); check("burst4", {24'd0, bus.mem_rdata}, 32'h11);
    rd(32'h0000_0201); check("burst5", {24'd0, bus.mem_rdata}, 32'h22);
    rd(32'h0000_0202); check("burst6", {24'd0, bus.mem_rdata}, 32'h33);
    rd(32'h0000_0203); check("burst7", {24'd0, bus.mem_rdata}, 32'h44);

    // TX: 12 writes reach the near-full threshold (16 - 4)
    for (int i = 0; i < 12; i++) begin
      wr(IO_DATA_ADDR, 8'h80 + 8'(i));
      if (i == 0) check("tx_first_vis", {24'd0, tx_data}, 32'h80);
      if (i == 10) check("full_at11", {31'd0, bus.io_buffer_full}, 32'd0);
    end
    check("full_at12", {31'd0, bus.io_buffer_full}, 32'd1);
    check("tx_valid12", {31'd0, tx_valid}, 32'd1);
    check("tx_head12", {24'd0, tx_data}, 32'h80);
    idle();
    tx_ready = 1'b1;
    tick();
    check("full_drop", {31'd0, bus.io_buffer_full}, 32'd0);
    for (int i = 1; i < 12; i++) exp_q.push_back(8'h80 + 8'(i));
    drain("drain12");

    // TX: fill to 16, push+pop at full, then a dropped byte
    for (int i = 0; i < 16; i++) begin
      wr(IO_DATA_ADDR, 8'h40 + 8'(i));
      if (i > 0) exp_q.push_back(8'h40 + 8'(i));
    end
    check("ovf_at16", {31'd0, tx_overflow}, 32'd0);
    check("head_at16", {24'd0, tx_data}, 32'h40);
    tx_ready = 1'b1;
    wr(IO_DATA_ADDR, 8'h99);
    exp_q.push_back(8'h99);
    tx_ready = 1'b0;
    check("ovf_pushpop", {31'd0, tx_overflow}, 32'd0);
    check("head_pushpop", {24'd0, tx_data}, 32'h41);
    wr(IO_DATA_ADDR, 8'h9A);
    check("ovf_drop", {31'd0, tx_overflow}, 32'd1);
    check("full_at_full", {31'd0, bus.io_buffer_full}, 32'd1);
    drain("drain16");
    check("ovf_sticky", {31'd0, tx_overflow}, 32'd1);

    // RX reads
    bus.mem_a  = IO_DATA_ADDR;
    bus.mem_wr = 1'b0;
    rx_valid   = 1'b1;
    rx_data    = 8'h41;
    #1;
    check("rx_ready1", {31'd0, rx_ready}, 32'd1);
    tick();
    check("rx_data", {24'd0, bus.mem_rdata}, 32'h41);
    rx_valid = 1'b0;
    #1;
    check("rx_ready0", {31'd0, rx_ready}, 32'd0);
    tick();
    check("rx_empty", {24'd0, bus.mem_rdata}, 32'h00);
    rd(32'h0000_0010);
    bus.mem_a = 32'h0003_0008;
    rx_valid  = 1'b1;
    #1;
    check("io_other_rxr", {31'd0, rx_ready}, 32'd0);
    tick();
    check("io_other_rd", {24'd0, bus.mem_rdata}, 32'h00);
    rx_valid = 1'b0;

    // Halt pulse lasts exactly one cycle
    idle();
    #1;
    check("halt_idle", {31'd0, halt}, 32'd0);
    wr(IO_HALT_ADDR, 8'h01);
    check("halt_hi", {31'd0, halt}, 32'd1);
    idle();
    tick();
    check("halt_lo", {31'd0, halt}, 32'd0);

    // Asynchronous reset in the middle of a TX burst
    for (int i = 0; i < 12; i++) wr(IO_DATA_ADDR, 8'hC0 + 8'(i));
    check("pre_rst_full", {31'd0, bus.io_buffer_full}, 32'd1);
    rd(32'h0000_0010);
    wr(IO_HALT_ADDR, 8'h00);
    check("pre_rst_halt", {31'd0, halt}, 32'd1);
    check("pre_rst_rdata", {24'd0, bus.mem_rdata}, 32'hA5);
    bus.mem_a  = IO_DATA_ADDR;
    bus.mem_wr = 1'b0;
    rx_valid   = 1'b1;
    rx_data    = 8'h55;
    #1;
    check("pre_rst_rxr", {31'd0, rx_ready}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_rdata", {24'd0, bus.mem_rdata}, 32'h00);
    check("arst_full", {31'd0, bus.io_buffer_full}, 32'd0);
    check("arst_halt", {31'd0, halt}, 32'd0);
    check("arst_ovf", {31'd0, tx_overflow}, 32'd0);
    check("arst_txv", {31'd0, tx_valid}, 32'd0);
    check("arst_rxr", {31'd0, rx_ready}, 32'd0);
    @(negedge clk);
    rx_valid = 1'b0;
    idle();
    rst_n = 1'b1;
    tick();
    check("post_rst_txv", {31'd0, tx_valid}, 32'd0);
    check("post_rst_ram", {24'd0, bus.mem_rdata}, 32'hA5);
    wr(IO_DATA_ADDR, 8'h5C);
    check("post_rst_push_v", {31'd0, tx_valid}, 32'd1);
    check("post_rst_push_d", {24'd0, tx_data}, 32'h5C);
    idle();
    tick();

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
